// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the regfile access controller: FSM state encoding
// and command opcode values.
package regfile_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/regfile_ctrl_init_seq.sv
// Post-reset clear sequencer for the regfile controller. Walks the clear
// address from 1 up to the top entry, one step per cycle while enabled, and
// raises done once the top entry has been issued. Only instantiated when
// REGFILE_CTRL_INIT_EN is defined.
module regfile_init_seq
    #(parameter int N = 3)
    (
        input  logic         clk,
        input  logic         rst,
        input  logic         en,
        output logic [N-1:0] addr,
        output logic         last,
        output logic         done
    );

    import regfile_ctrl_pkg::*;

    // Entry 0 is hard-wired, so the walk ends on the all-ones address.
    assign last = (addr == '1);

    // Advance the clear address each enabled cycle and latch completion.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= N'(1);
            done <= 1'b0;
        end else if (en && !done) begin
            addr <= addr + N'(1);
            if (last) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Command-driven access controller owning the regfile write port and both
// read ports. Commands arrive over valid/ready; read data is returned on a
// held valid/ready response port. Defining REGFILE_CTRL_INIT_EN adds a
// post-reset pass that zeroes every writable register before IDLE.
module regfile_ctrl
    #(
        parameter int N = 3,
        parameter int W = 8
    )
    (
        input  logic         clk,
        input  logic         rst,
        input  logic         cmd_valid,
        output logic         cmd_ready,
        input  logic         cmd_op,
        input  logic [N-1:0] cmd_rd,
        input  logic [N-1:0] cmd_rs1,
        input  logic [N-1:0] cmd_rs2,
        input  logic [W-1:0] cmd_data,
        output logic         rf_we,
        output logic [N-1:0] rf_addr_rd,
        output logic [N-1:0] rf_addr_rs1,
        output logic [N-1:0] rf_addr_rs2,
        output logic [W-1:0] rf_data_in,
        input  logic [W-1:0] rf_rs1,
        input  logic [W-1:0] rf_rs2,
        output logic         rsp_valid,
        input  logic         rsp_ready,
        output logic [W-1:0] rsp_rs1,
        output logic [W-1:0] rsp_rs2,
        output logic         init_done
    );

    import regfile_ctrl_pkg::*;

`ifdef REGFILE_CTRL_INIT_EN
    localparam state_t RESET_STATE = INIT;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t         state_q;
    state_t         state_d;

    logic           rf_we_d;
    logic [N-1:0]   rf_addr_rd_d;
    logic [N-1:0]   rf_addr_rs1_d;
    logic [N-1:0]   rf_addr_rs2_d;
    logic [W-1:0]   rf_data_in_d;
    logic           rsp_valid_d;
    logic [W-1:0]   rsp_rs1_d;
    logic [W-1:0]   rsp_rs2_d;

`ifdef REGFILE_CTRL_INIT_EN
    logic [N-1:0]   init_addr;
    logic           init_last;
    logic           init_seq_done;

    regfile_init_seq #(.N(N)) u_init_seq (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == INIT),
        .addr (init_addr),
        .last (init_last),
        .done (init_seq_done)
    );

    assign init_done = init_seq_done;
`else
    // Without the clear pass the controller is usable straight out of reset.
    assign init_done = 1'b1;
`endif

    // Commands are only taken while idle; the sender holds them otherwise.
    assign cmd_ready = (state_q == IDLE);

    // Next-state and next-output decode; rf_we is a one-cycle pulse, every
    // other registered output holds unless this state updates it.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        rf_we_d       = 1'b0;
        rf_addr_rd_d  = rf_addr_rd;
        rf_addr_rs1_d = rf_addr_rs1;
        rf_addr_rs2_d = rf_addr_rs2;
        rf_data_in_d  = rf_data_in;
        rsp_valid_d   = rsp_valid;
        rsp_rs1_d     = rsp_rs1;
        rsp_rs2_d     = rsp_rs2;

        case (state_q)
            INIT: begin
`ifdef REGFILE_CTRL_INIT_EN
                rf_we_d      = 1'b1;
                rf_addr_rd_d = init_addr;
                rf_data_in_d = '0;
                if (init_last) begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end

            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == OP_WRITE) begin
                        // Register 0 is read-only: address and data are still
                        // latched, but no write strobe is issued.
                        rf_we_d      = (cmd_rd != '0);
                        rf_addr_rd_d = cmd_rd;
                        rf_data_in_d = cmd_data;
                        state_d      = WR;
                    end else begin
                        rf_addr_rs1_d = cmd_rs1;
                        rf_addr_rs2_d = cmd_rs2;
                        state_d       = RD;
                    end
                end
            end

            WR: begin
                state_d = IDLE;
            end

            RD: begin
                rsp_rs1_d   = rf_rs1;
                rsp_rs2_d   = rf_rs2;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end

            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_STATE;
            rf_we       <= 1'b0;
            rf_addr_rd  <= '0;
            rf_addr_rs1 <= '0;
            rf_addr_rs2 <= '0;
            rf_data_in  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rs1     <= '0;
            rsp_rs2     <= '0;
        end else begin
            state_q     <= state_d;
            rf_we       <= rf_we_d;
            rf_addr_rd  <= rf_addr_rd_d;
            rf_addr_rs1 <= rf_addr_rs1_d;
            rf_addr_rs2 <= rf_addr_rs2_d;
            rf_data_in  <= rf_data_in_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rs1     <= rsp_rs1_d;
            rsp_rs2     <= rsp_rs2_d;
        end
    end

endmodule

// File: doc/regfile_ctrl.md
# regfile_ctrl

Command-driven access controller for the `regfile` block: the hardware initiator that owns the regfile's write port and both read ports. Upstream logic issues write or read-pair commands over a valid/ready handshake. The block sequences them onto the regfile's single-cycle ports and returns read data through a held valid/ready response port. After reset it can optionally clear every writable register before accepting traffic.

## Interface
- `N`, 3: address width; the regfile has 2^N entries.
- `W`, 8: data width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when `cmd_valid` is also high.
- `cmd_op`  in  1  0 = READ, 1 = WRITE.
- `cmd_rd`  in  N  write address.
- `cmd_rs1`, `cmd_rs2`  in  N  read addresses.
- `cmd_data`  in  W  write data.
- `rf_we`  out  1  regfile write enable.
- `rf_addr_rd`  out  N  regfile write address.
- `rf_addr_rs1`, `rf_addr_rs2`  out  N  regfile read addresses.
- `rf_data_in`  out  W  regfile write data.
- `rf_rs1`, `rf_rs2`  in  W  regfile combinational read data.
- `rsp_valid`  out  1  read response held.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rs1`, `rsp_rs2`  out  W  read response data.
- `init_done`  out  1  high once the controller has reached IDLE for the first time; stays high until reset.

## Operation
- All `rf_*` and `rsp_*` outputs are registered.
- State machine:
  - **INIT:** clears the register file (macro-dependent, see Configuration).
  - **IDLE:** `cmd_ready` = 1. On an accepted WRITE, go to WR. On an accepted READ, go to RD.
  - **WR:** latch `cmd_rd` and `cmd_data` at acceptance. In WR, drive `rf_we` = 1 for exactly one cycle, except when `cmd_rd` == 0: in that case `rf_we` stays 0, because register 0 is not writable. Then return to IDLE.
  - **RD:** latch `cmd_rs1` and `cmd_rs2` onto `rf_addr_rs1` and `rf_addr_rs2` at acceptance. At the end of RD, capture `rf_rs1` and `rf_rs2` into `rsp_rs1` and `rsp_rs2`, set `rsp_valid`, and go to RESP.
  - **RESP:** hold `rsp_valid` and the data stable until `rsp_ready` = 1. Clear `rsp_valid` on that edge and return to IDLE.
- `cmd_ready` is 0 in every state except IDLE. Commands presented outside IDLE are ignored, not dropped: the sender keeps `cmd_valid` asserted until accepted.
- `rf_addr_rs1`, `rf_addr_rs2`, `rf_addr_rd` and `rf_data_in` keep their last value when not in use. Only `rf_we` qualifies a write.
- Reset values: state = INIT if the macro is defined, else IDLE.
  - All `rf_*` outputs = 0.
  - `rsp_valid` = 0; `rsp_rs1` = `rsp_rs2` = 0.
  - `init_done` = 0 with the macro, 1 without it.
- Reset asserted mid-operation aborts the command in flight with no further `rf_we` pulse. A held response is discarded.

## Timing
- WRITE accepted at edge k: `rf_we` high during cycle k+1, so the regfile writes at edge k+2. `cmd_ready` returns at cycle k+2.
- READ accepted at edge k: addresses valid during cycle k+1, data captured at edge k+2, `rsp_valid` high from cycle k+2.
- With `rsp_ready` held high, the response is consumed at edge k+3 and `cmd_ready` returns at cycle k+3.
- Peak throughput:
  - writes: 1 per 2 cycles.
  - reads: 1 per 3 cycles.
- Read-after-write ordering is guaranteed by serialization; no forwarding is needed.
- A READ of an address written by the immediately preceding WRITE returns the new data.

## Configuration
- `REGFILE_CTRL_INIT_EN` defined:
  - After reset, the INIT state runs an address counter from 1 to 2^N−1.
  - One `rf_we` pulse per cycle, with `rf_addr_rd` = counter and `rf_data_in` = 0.
  - That is 2^N−1 consecutive cycles with `cmd_ready` = 0.
  - Then go to IDLE and set `init_done`.
- Undefined: the INIT state and its counter are absent. The controller leaves reset in IDLE with `init_done` = 1.

## Structure
- Package `regfile_ctrl_pkg`:
  - state enum: INIT, IDLE, WR, RD, RESP.
  - op constants: OP_READ = 0, OP_WRITE = 1.
- One sub-module is natural: `regfile_init_seq`. It holds the clear-address counter and its done flag, and is instantiated only under `REGFILE_CTRL_INIT_EN`.

## Test plan
- Reset with macro, N=3:
  - exactly 7 `rf_we` pulses, addresses 1..7, data 0, on consecutive cycles;
  - `cmd_ready` = 0 throughout;
  - then `init_done` = 1 and `cmd_ready` = 1.
- WRITE rd=5 data=0xA7, then READ rs1=5 rs2=0:
  - a single `rf_we` pulse with `rf_addr_rd` = 5;
  - `rsp_rs1` = 0xA7, `rsp_rs2` = 0x00;
  - `rsp_valid` asserted 2 cycles after READ acceptance.
- WRITE rd=0 data=0xFF: `rf_we` never asserted; `cmd_ready` returns after 2 cycles.
- READ with `rsp_ready` held low for 4 cycles:
  - `rsp_valid` and the data stay stable;
  - `cmd_ready` = 0 throughout;
  - exactly one response is consumed when `rsp_ready` rises.
- Back-to-back random WRITEs to registers 1..7, then 10 random READ pairs: every response matches the bench scoreboard.
- Reset asserted during RESP, then released:
  - `rsp_valid` = 0 immediately;
  - no `rf_we` pulse apart from those of a new INIT sequence.
